imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Parametrised, registered immediate-generation stage for the RV pipeline, sitting between decode (D) and execute (E). It decodes the immediate for the I/S/B/J/U formats plus CSR-immediate and shift-amount formats at XLEN 32 or 64. It also precomputes the PC-relative target PCD + ImmExt and flags illegal ImmSrc encodings. Results are presented through a valid/ready handshake backed by a 2-entry skid buffer, so a stalled E stage never drops an instruction.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  D stage presents an instruction.
- in_ready  out  1  block can accept this cycle.
- InstD  in  32  instruction word.
- ImmSrcD  in  3  immediate format select.
- PCD  in  XLEN  PC of InstD.
- FlushD  in  1  synchronous pipeline flush; discards all held entries.
- out_valid  out  1  ImmExtE/TargetE/ImmErrE valid.
- out_ready  in  1  E stage consumes this cycle.
- ImmExtE  out  XLEN  extended immediate.
- TargetE  out  XLEN  PCD + ImmExt, modulo 2^XLEN.
- ImmErrE  out  1  ImmSrcD was 3'b111.

## Operation
- Formats (s = InstD[31], sign-extended to XLEN unless stated):
  - 000 I: s, InstD[30:20].
  - 001 S: s, InstD[30:25], InstD[11:7].
  - 010 B: s, InstD[7], InstD[30:25], InstD[11:8], 0.
  - 011 J: s, InstD[19:12], InstD[20], InstD[30:21], 0.
  - 100 U: InstD[31:12], 12'b0; for XLEN=64, bits 63:32 = s.
  - 101 Z: zero-extended InstD[19:15].
  - 110 shamt: zero-extended InstD[24:20] (XLEN=32) or InstD[25:20] (XLEN=64).
  - 111: ImmExt = 0, ImmErr = 1.
- ImmErr = 0 for every other encoding.
- TargetE is computed for every format; consumers ignore it where unused. Overflow wraps silently.
- Storage: main entry (drives outputs) plus one skid entry. Each entry holds {ImmExt, Target, ImmErr}.
- in_ready = !skid_valid, a pure register output that does not depend combinationally on out_ready.
- A transfer happens on in_valid && in_ready; a consume happens on out_valid && out_ready.
- Transitions:
  - EMPTY: accept loads main; goes to ONE.
  - ONE, consume without accept: goes to EMPTY.
  - ONE, accept without consume: new item to skid; goes to FULL.
  - ONE, accept and consume together: new item replaces main; stays ONE.
  - FULL, consume: skid moves to main; goes to ONE. No accept is possible in FULL.
- Order is strictly FIFO; no entry is duplicated or dropped except by FlushD.
- FlushD has priority over all other events: both entries are invalidated next edge, and a same-cycle input is dropped. Data fields need not clear.

## Timing
- Reset (asserted, async): out_valid=0, ImmExtE=0, TargetE=0, ImmErrE=0, skid empty. in_ready=1 while in reset and after release.
- Latency: 1 cycle from accept into EMPTY, or into ONE with a same-cycle consume, to out_valid.
- Throughput: 1 per cycle while out_ready is held high.
- Output fields are stable while out_valid && !out_ready.
- in_ready falls the cycle after the second unconsumed accept. It rises the cycle after a consume in FULL.
- Reset deasserted mid-stream: all in-flight entries are lost. The first accept after reset yields out_valid on the following cycle.
- X on InstD/ImmSrcD/PCD while in_valid=0 must not propagate into state.

## Test plan
- I and S immediates, XLEN=32, out_ready=1:
  - InstD=0xFFF00093, ImmSrc=000 → ImmExtE=0xFFFFFFFF one cycle later, ImmErrE=0.
  - InstD=0x00112223, ImmSrc=001 → ImmExtE=0x00000004.
- B target: InstD=0xFE000EE3, ImmSrc=010, PCD=0x100 → ImmExtE=0xFFFFFFFC, TargetE=0x000000FC.
- J wrap: InstD=0x0080006F, ImmSrc=011, PCD=0xFFFFFFFC → ImmExtE=0x8, TargetE=0x4.
- U/Z/shamt/illegal:
  - InstD=0x123450B7, U → 0x12345000.
  - XLEN=64, InstD=0x800000B7, U → 0xFFFFFFFF80000000.
  - InstD=0x000FD073, Z → 0x1F.
  - XLEN=64, InstD=0x03F0D093, shamt → 0x3F.
  - ImmSrc=111 → ImmExtE=0, ImmErrE=1.
- Backpressure: out_ready=0, push I immediates 1, 2, 3 on consecutive cycles.
  - 1 and 2 are accepted; in_ready=0 on the cycle 3 is offered.
  - Raise out_ready → outputs 1, 2, 3 in order, no loss.
- Flush/reset: fill both entries, assert FlushD alongside a valid input → next cycle out_valid=0, in_ready=1, input dropped. Repeat with rst_n pulsed low mid-cycle → outputs zero immediately.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV immediate generator between decode and execute: decodes I/S/B/J/U/Z/shamt
// immediates, precomputes PC + imm, and hands results to E through a 2-entry skid buffer.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | no held result, out_valid low
// ST_ONE   | main entry valid, skid empty, in_ready high
// ST_FULL  | main and skid valid, in_ready low
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     InstD,
  input  logic [2:0]      ImmSrcD,
  input  logic [XLEN-1:0] PCD,
  input  logic            FlushD,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] TargetE,
  output logic            ImmErrE
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            err;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [XLEN-1:0] imm_ext;
  logic            imm_err;
  logic            sgn;
  logic            skid_valid;
  logic            accept;
  logic            consume;
  logic            load_main;
  logic            load_skid;
  logic            pop_skid;
  logic            unused_opcode;

  // Opcode bits never contribute to any immediate format.
  assign unused_opcode = ^InstD[6:0];
  assign sgn           = InstD[31];

  always_comb begin
    imm_ext = '0;
    imm_err = 1'b0;
    case (ImmSrcD)
      3'b000: imm_ext = {{(XLEN-12){sgn}}, InstD[31:20]};
      3'b001: imm_ext = {{(XLEN-12){sgn}}, InstD[31:25], InstD[11:7]};
      3'b010: imm_ext = {{(XLEN-12){sgn}}, InstD[7], InstD[30:25], InstD[11:8], 1'b0};
      3'b011: imm_ext = {{(XLEN-20){sgn}}, InstD[19:12], InstD[20], InstD[30:21], 1'b0};
      // Shifting out the top 12 copies of the sign leaves a 32-bit U value sign-extended to XLEN.
      3'b100: imm_ext = {{(XLEN-20){sgn}}, InstD[31:12]} << 12;
      3'b101: imm_ext = {{(XLEN-5){1'b0}}, InstD[19:15]};
      3'b110: begin
        if (XLEN == 64) imm_ext = {{(XLEN-6){1'b0}}, InstD[25:20]};
        else            imm_ext = {{(XLEN-5){1'b0}}, InstD[24:20]};
      end
      default: begin
        imm_ext = '0;
        imm_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    new_entry        = '0;
    new_entry.imm    = imm_ext;
    new_entry.target = PCD + imm_ext;
    new_entry.err    = imm_err;
  end

  // Handshake qualifiers; in_ready and out_valid come straight from state_q.
  assign skid_valid = (state_q == ST_FULL);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FlushD) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_d = ST_FULL;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_FULL:  if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = !skid_valid;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (!FlushD) begin
      case (state_q)
        ST_EMPTY: load_main = accept;
        ST_ONE: begin
          load_main = accept && consume;
          load_skid = accept && !consume;
        end
        ST_FULL:  pop_skid = consume;
        default: ;
      endcase
    end
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main)     main_d = new_entry;
    else if (pop_skid) main_d = skid_q;
    if (load_skid)     skid_d = new_entry;
  end

  // Data fields only move on accept/consume, so undriven inputs while idle never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign ImmExtE = main_q.imm;
  assign TargetE = main_q.target;
  assign ImmErrE = main_q.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus,
// expectations come from an independent immediate model queued on each accept.
module tb_imm_gen_stage;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [63:0] pc;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst_d;
  logic [2:0]  src_d;
  logic [63:0] pc_d;
  logic        flush_d;
  logic        out_ready;
  logic        rdy_manual;
  logic        rand_rdy;
  logic        rdy_rand_val;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32, tgt32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64, tgt64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_chk;
  int   n_pass;

  assign out_ready = rand_rdy ? rdy_rand_val : rdy_manual;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .InstD(inst_d), .ImmSrcD(src_d), .PCD(pc_d[31:0]), .FlushD(flush_d),
    .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExtE(imm32), .TargetE(tgt32), .ImmErrE(err32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .InstD(inst_d), .ImmSrcD(src_d), .PCD(pc_d), .FlushD(flush_d),
    .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExtE(imm64), .TargetE(tgt64), .ImmErrE(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rdy_rand_val <= 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] inst, input logic [2:0] src,
                                 input logic [63:0] pc, input int xlen);
    exp_t        r;
    logic [63:0] imm;
    logic [63:0] mask;
    logic        s;
    s    = inst[31];
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (src)
      3'b000:  imm = {{52{s}}, inst[31:20]};
      3'b001:  imm = {{52{s}}, inst[31:25], inst[11:7]};
      3'b010:  imm = {{51{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b011:  imm = {{43{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
      3'b100:  imm = {{32{s}}, inst[31:12], 12'b0};
      3'b101:  imm = {59'b0, inst[19:15]};
      3'b110:  imm = (xlen == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
      default: imm = 64'b0;
    endcase
    r.imm = imm & mask;
    r.tgt = (pc + imm) & mask;
    r.err = (src == 3'b111);
    return r;
  endfunction

  // Offer one item; push expectations on the negedge before the accepting edge.
  task automatic send(input logic [31:0] inst, input logic [2:0] src, input logic [63:0] pc);
    bit got;
    got      = 1'b0;
    inst_d   = inst;
    src_d    = src;
    pc_d     = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready64) q64.push_back(model(inst, src, pc, 64));
      if (in_ready32) begin
        q32.push_back(model(inst, src, pc, 32));
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    inst_d   = 'x;
    src_d    = 'x;
    pc_d     = 'x;
    if (!got) chk("send_timeout", 64'(in_ready32), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
    #1;
    chk({tag, "_q32"}, 64'(q32.size()), 64'd0);
    chk({tag, "_q64"}, 64'(q64.size()), 64'd0);
  endtask

  logic        stall32_q, stall64_q;
  logic [63:0] hold_imm32, hold_tgt32, hold_imm64, hold_tgt64;
  exp_t        m32, m64;

  always @(negedge clk) begin
    if (rst_n && out_valid32 && out_ready) begin
      if (q32.size() == 0) chk("q32_underflow", 64'(q32.size()), 64'd1);
      else begin
        m32 = q32.pop_front();
        chk("imm32", 64'(imm32), m32.imm);
        chk("tgt32", 64'(tgt32), m32.tgt);
        chk("err32", 64'(err32), 64'(m32.err));
      end
    end
    if (rst_n && stall32_q && out_valid32) begin
      chk("hold_imm32", 64'(imm32), hold_imm32);
      chk("hold_tgt32", 64'(tgt32), hold_tgt32);
    end
    stall32_q  <= rst_n && out_valid32 && !out_ready;
    hold_imm32 <= 64'(imm32);
    hold_tgt32 <= 64'(tgt32);
  end

  always @(negedge clk) begin
    if (rst_n && out_valid64 && out_ready) begin
      if (q64.size() == 0) chk("q64_underflow", 64'(q64.size()), 64'd1);
      else begin
        m64 = q64.pop_front();
        chk("imm64", imm64, m64.imm);
        chk("tgt64", tgt64, m64.tgt);
        chk("err64", 64'(err64), 64'(m64.err));
      end
    end
    if (rst_n && stall64_q && out_valid64) begin
      chk("hold_imm64", imm64, hold_imm64);
      chk("hold_tgt64", tgt64, hold_tgt64);
    end
    stall64_q  <= rst_n && out_valid64 && !out_ready;
    hold_imm64 <= imm64;
    hold_tgt64 <= tgt64;
  end

  vec_t dir_vecs[$];

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    inst_d     = '0;
    src_d      = '0;
    pc_d       = '0;
    flush_d    = 1'b0;
    rdy_manual = 1'b1;
    rand_rdy   = 1'b0;
    n_chk      = 0;
    n_pass     = 0;

    #12;
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    chk("rst_in_ready32", 64'(in_ready32), 64'd1);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_tgt32", 64'(tgt32), 64'd0);
    chk("rst_err32", 64'(err32), 64'd0);
    chk("rst_out_valid64", 64'(out_valid64), 64'd0);
    chk("rst_in_ready64", 64'(in_ready64), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir_vecs = '{
      '{32'hFFF0_0093, 3'b000, 64'h0},
      '{32'h0011_2223, 3'b001, 64'h0},
      '{32'hFE00_0EE3, 3'b010, 64'h100},
      '{32'h0080_006F, 3'b011, 64'hFFFF_FFFC},
      '{32'h1234_50B7, 3'b100, 64'h0},
      '{32'h8000_00B7, 3'b100, 64'h0},
      '{32'h000F_D073, 3'b101, 64'h0},
      '{32'h03F0_D093, 3'b110, 64'h0},
      '{32'hDEAD_BEEF, 3'b111, 64'h2000}
    };
    foreach (dir_vecs[i]) send(dir_vecs[i].inst, dir_vecs[i].src, dir_vecs[i].pc);
    drain("dir");

    send(32'h0050_0093, 3'b000, 64'h40);
    @(negedge clk);
    chk("lat_valid32", 64'(out_valid32), 64'd1);
    chk("lat_valid64", 64'(out_valid64), 64'd1);
    @(posedge clk);
    #1;

    // Backpressure: items 1 and 2 fill both entries, 3 must wait.
    rdy_manual = 1'b0;
    send(32'h0010_0093, 3'b000, 64'h0);
    send(32'h0020_0093, 3'b000, 64'h0);
    inst_d   = 32'h0030_0093;
    src_d    = 3'b000;
    pc_d     = 64'h0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready32", 64'(in_ready32), 64'd0);
    chk("bp_in_ready64", 64'(in_ready64), 64'd0);
    chk("bp_q_depth", 64'(q32.size()), 64'd2);
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    send(32'h0030_0093, 3'b000, 64'h0);
    drain("bp");

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++)
      send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    rand_rdy   = 1'b0;
    rdy_manual = 1'b1;
    drain("rand");

    // Flush while FULL with a valid input alongside.
    @(posedge clk);
    #1;
    rdy_manual = 1'b0;
    send(32'h0070_0093, 3'b000, 64'h10);
    send(32'h0080_0093, 3'b000, 64'h20);
    flush_d  = 1'b1;
    in_valid = 1'b1;
    inst_d   = 32'h0090_0093;
    src_d    = 3'b000;
    pc_d     = 64'h30;
    @(posedge clk);
    #1;
    flush_d  = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    chk("flush_full_valid32", 64'(out_valid32), 64'd0);
    chk("flush_full_ready32", 64'(in_ready32), 64'd1);
    chk("flush_full_valid64", 64'(out_valid64), 64'd0);

    // Flush while ONE: in_ready is high, yet the same-cycle input must be dropped.
    send(32'h00A0_0093, 3'b000, 64'h40);
    flush_d  = 1'b1;
    in_valid = 1'b1;
    inst_d   = 32'h00B0_0093;
    @(posedge clk);
    #1;
    flush_d  = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    chk("flush_one_valid32", 64'(out_valid32), 64'd0);
    chk("flush_one_valid64", 64'(out_valid64), 64'd0);

    // Asynchronous reset mid-cycle with both entries full.
    send(32'h1234_50B7, 3'b100, 64'h80);
    send(32'h0011_2223, 3'b001, 64'h90);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid32", 64'(out_valid32), 64'd0);
    chk("arst_ready32", 64'(in_ready32), 64'd1);
    chk("arst_imm32", 64'(imm32), 64'd0);
    chk("arst_tgt32", 64'(tgt32), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_valid64", 64'(out_valid64), 64'd0);
    q32.delete();
    q64.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'hFFF0_0093, 3'b000, 64'h500);
    @(negedge clk);
    chk("post_rst_lat32", 64'(out_valid32), 64'd1);
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
